// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared funct3 codes, FSM state type and wait-state counter width
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane steering for stores and sign/zero extension for loads
module dmem_lane_align
  import mem_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata_word,
  output logic [3:0]  o_be,
  output logic [31:0] o_wword,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata_word[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rdata_word[31:16] : i_rdata_word[15:0];

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    o_be    = 4'b0000;
    o_wword = i_wdata;
    o_rdata = 32'h0;
    o_err   = 1'b0;
    case (i_funct3)
      F3_B: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wword = {4{i_wdata[7:0]}};
        o_rdata = {{24{w_byte[7]}}, w_byte};
      end
      F3_H: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wword = {2{i_wdata[15:0]}};
        o_rdata = {{16{w_half[15]}}, w_half};
        o_err   = i_addr_lo[0];
      end
      F3_W: begin
        o_be    = 4'b1111;
        o_rdata = i_rdata_word;
        o_err   = |i_addr_lo;
      end
      F3_BU: begin
        o_rdata = {24'h0, w_byte};
        o_err   = i_we;
      end
      F3_HU: begin
        o_rdata = {16'h0, w_half};
        o_err   = i_we | i_addr_lo[0];
      end
      default: o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data-memory responder with programmable wait states
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DEPTH_WORDS   = 1024,
  parameter int LATENCY       = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic                     i_req_we,
  input  logic [2:0]               i_req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0]    i_req_wdata,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [DATA_WIDTH-1:0]    o_rsp_rdata,
  output logic                     o_rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] L_CNT_INIT = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam bit L_ZERO_LAT = (LATENCY == 0);

  state_t                   r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_we;
  logic [2:0]               r_funct3;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic                     r_rsp_valid;
  logic [DATA_WIDTH-1:0]    r_rsp_rdata;
  logic                     r_rsp_err;
  logic [DATA_WIDTH-1:0]    r_mem [DEPTH_WORDS];

  logic                     w_accept;
  logic                     w_enter_resp;
  logic                     w_eff_we;
  logic [2:0]               w_eff_funct3;
  logic [ADDRESS_WIDTH-1:0] w_eff_addr;
  logic [DATA_WIDTH-1:0]    w_eff_wdata;
  logic [IDX_W-1:0]         w_idx;
  logic                     w_oor;
  logic [3:0]               w_be;
  logic [DATA_WIDTH-1:0]    w_wword;
  logic [DATA_WIDTH-1:0]    w_ld_data;
  logic                     w_lane_err;
  logic                     w_err;
  logic                     w_do_write;

  assign o_req_ready = (r_state == ST_IDLE) && !i_rst;
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_enter_resp = (w_accept && L_ZERO_LAT) || ((r_state == ST_WAIT) && (r_cnt == '0));

  // With zero wait states the access resolves straight from the request pins on the accept edge.
  assign w_eff_we     = (r_state == ST_IDLE) ? i_req_we     : r_we;
  assign w_eff_funct3 = (r_state == ST_IDLE) ? i_req_funct3 : r_funct3;
  assign w_eff_addr   = (r_state == ST_IDLE) ? i_req_addr   : r_addr;
  assign w_eff_wdata  = (r_state == ST_IDLE) ? i_req_wdata  : r_wdata;

  assign w_idx = w_eff_addr[2 +: IDX_W];
  assign w_oor = |w_eff_addr[ADDRESS_WIDTH-1:2+IDX_W];

  dmem_lane_align u_align (
    .i_we         (w_eff_we),
    .i_funct3     (w_eff_funct3),
    .i_addr_lo    (w_eff_addr[1:0]),
    .i_wdata      (w_eff_wdata),
    .i_rdata_word (r_mem[w_idx]),
    .o_be         (w_be),
    .o_wword      (w_wword),
    .o_rdata      (w_ld_data),
    .o_err        (w_lane_err)
  );

  assign w_err      = w_lane_err || w_oor;
  assign w_do_write = w_enter_resp && w_eff_we && !w_err && !i_rst;

  always_ff @(posedge i_clk) begin
    if (w_do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_enter_resp) begin
        r_state     <= ST_RESP;
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_err;
        r_rsp_rdata <= (w_err || w_eff_we) ? '0 : w_ld_data;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_we     <= i_req_we;
            r_funct3 <= i_req_funct3;
            r_addr   <= i_req_addr;
            r_wdata  <= i_req_wdata;
            if (!L_ZERO_LAT) begin
              r_state <= ST_WAIT;
              r_cnt   <= L_CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed vector bench for dmem_responder at LATENCY 1 and 0
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [2:0]  req_f3    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.LATENCY(1)) u_lat1 (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_req_we(req_we[0]), .i_req_funct3(req_f3[0]),
    .i_req_addr(req_addr[0]), .i_req_wdata(req_wdata[0]),
    .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
    .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0])
  );

  dmem_responder #(.LATENCY(0)) u_lat0 (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_req_we(req_we[1]), .i_req_funct3(req_f3[1]),
    .i_req_addr(req_addr[1]), .i_req_wdata(req_wdata[1]),
    .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
    .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1])
  );

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input int s, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_we[s] = we; req_f3[s] = f3; req_addr[s] = addr; req_wdata[s] = wd;
  endtask

  // Waits for ready, issues one request and returns the response plus cycles from accept to rsp_valid.
  task automatic do_req(input int s, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready[s] && n < 50) begin
      @(negedge clk);
      n++;
    end
    drive(s, we, f3, addr, wd);
    req_valid[s] = 1'b1;
    @(posedge clk);
    #1 req_valid[s] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid[s] && lat < 50);
    rd = rsp_rdata[s];
    er = rsp_err[s];
  endtask

  task automatic add(input string nm, input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] er_d, input logic er);
    vec_t v;
    v.name = nm; v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd;
    v.exp_rdata = er_d; v.exp_err = er;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] held_rd;

    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; rsp_ready[s] = 1'b1;
      drive(s, 1'b0, 3'b000, 32'h0, 32'h0);
    end

    add("sw_10",      1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        0);
    add("lw_10",      0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 0);
    add("sb_11",      1, 3'b000, 32'h11,   32'h12345680, 32'h0,        0);
    add("lb_11",      0, 3'b000, 32'h11,   32'h0,        32'hFFFFFF80, 0);
    add("lbu_11",     0, 3'b100, 32'h11,   32'h0,        32'h00000080, 0);
    add("lw_after_sb",0, 3'b010, 32'h10,   32'h0,        32'hDEAD80EF, 0);
    add("sh_12",      1, 3'b001, 32'h12,   32'hAAAA8001, 32'h0,        0);
    add("lh_12",      0, 3'b001, 32'h12,   32'h0,        32'hFFFF8001, 0);
    add("lhu_12",     0, 3'b101, 32'h12,   32'h0,        32'h00008001, 0);
    add("lw_after_sh",0, 3'b010, 32'h10,   32'h0,        32'h800180EF, 0);
    add("lb_12",      0, 3'b000, 32'h12,   32'h0,        32'h00000001, 0);
    add("lh_10",      0, 3'b001, 32'h10,   32'h0,        32'hFFFF80EF, 0);
    add("lbu_10",     0, 3'b100, 32'h10,   32'h0,        32'h000000EF, 0);
    add("lw_mis_13",  0, 3'b010, 32'h13,   32'h0,        32'h0,        1);
    add("sh_mis_11",  1, 3'b001, 32'h11,   32'hFFFFFFFF, 32'h0,        1);
    add("lw_unchg",   0, 3'b010, 32'h10,   32'h0,        32'h800180EF, 0);
    add("ld_f3_011",  0, 3'b011, 32'h10,   32'h0,        32'h0,        1);
    add("lw_oor",     0, 3'b010, 32'h1000, 32'h0,        32'h0,        1);
    add("sw_oor",     1, 3'b010, 32'h1000, 32'h55555555, 32'h0,        1);
    add("st_f3_100",  1, 3'b100, 32'h10,   32'h0,        32'h0,        1);
    add("lw_unchg2",  0, 3'b010, 32'h10,   32'h0,        32'h800180EF, 0);
    add("sw_last",    1, 3'b010, 32'hFFC,  32'h01020304, 32'h0,        0);
    add("lw_last",    0, 3'b010, 32'hFFC,  32'h0,        32'h01020304, 0);

    // Reset state
    #2;
    chk("rst_req_ready", {31'h0, req_ready[0]}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid[0]}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata[0], 32'h0);
    chk("rst_rsp_err",   {31'h0, rsp_err[0]}, 32'h0);
    chk("rst_req_ready_l0", {31'h0, req_ready[1]}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", {31'h0, req_ready[0]}, 32'h1);

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < vecs.size(); i++) begin
        do_req(s, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat);
        chk($sformatf("L%0d_%s_rdata", 1 - s, vecs[i].name), rd, vecs[i].exp_rdata);
        chk($sformatf("L%0d_%s_err", 1 - s, vecs[i].name), {31'h0, er}, {31'h0, vecs[i].exp_err});
        chk($sformatf("L%0d_%s_lat", 1 - s, vecs[i].name), lat, (s == 0) ? 2 : 1);
      end
    end

    // Backpressure: response held while a second request waits on the pins
    rsp_ready[0] = 1'b0;
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    chk("bp_first_rdata", rd, 32'h800180EF);
    drive(0, 1'b0, 3'b101, 32'h12, 32'h0);
    req_valid[0] = 1'b1;
    held_rd = rd;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_rsp_valid", {31'h0, rsp_valid[0]}, 32'h1);
      chk("bp_rdata_hold", rsp_rdata[0], held_rd);
      chk("bp_err_hold", {31'h0, rsp_err[0]}, 32'h0);
      chk("bp_req_ready", {31'h0, req_ready[0]}, 32'h0);
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("hs_rsp_valid_clr", {31'h0, rsp_valid[0]}, 32'h0);
    chk("hs_req_ready", {31'h0, req_ready[0]}, 32'h1);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid[0] && lat < 50);
    chk("bp_second_lat", lat, 2);
    chk("bp_second_rdata", rsp_rdata[0], 32'h00008001);

    // Reset during WAIT drops the store
    do_req(0, 1'b1, 3'b010, 32'h20, 32'h11111111, rd, er, lat);
    @(negedge clk);
    drive(0, 1'b1, 3'b010, 32'h20, 32'h12345678);
    req_valid[0] = 1'b1;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("wait_rst_rsp_valid", {31'h0, rsp_valid[0]}, 32'h0);
    chk("wait_rst_req_ready", {31'h0, req_ready[0]}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    do_req(0, 1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
    chk("wait_rst_lw_20", rd, 32'h11111111);
    chk("wait_rst_lw_lat", lat, 2);

    // Zero wait states: reset during RESP keeps the performed store
    do_req(1, 1'b1, 3'b010, 32'h20, 32'h11111111, rd, er, lat);
    chk("l0_sw_lat", lat, 1);
    @(negedge clk);
    rsp_ready[1] = 1'b0;
    drive(1, 1'b1, 3'b010, 32'h20, 32'h12345678);
    req_valid[1] = 1'b1;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    chk("l0_resp_valid", {31'h0, rsp_valid[1]}, 32'h1);
    rst = 1'b1;
    #1;
    chk("l0_rst_rsp_valid", {31'h0, rsp_valid[1]}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rsp_ready[1] = 1'b1;
    do_req(1, 1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
    chk("l0_rst_lw_20", rd, 32'h12345678);
    chk("l0_rst_lw_lat", lat, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
